// File: rtl/kyber_rej_sampler.sv
// rtl/kyber_rej_sampler.sv - Kyber uniform rejection sampler (SampleNTT/Parse) behind the SHAKE128 XOF.
// Optional rejected-candidate counter o_rej_cnt is built when REJ_SAMPLER_STATS_EN is defined.
module kyber_rej_sampler #(
    parameter int BW_DATA = 64,
    parameter int BW_COEF = 12,
    parameter int Q       = 3329,
    parameter int NCOEF   = 256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [BW_DATA-1:0] i_ibytes,
    input  logic               i_ibytes_valid,
    output logic               o_ibytes_ready,
    output logic [BW_COEF-1:0] o_coef,
    output logic               o_coef_valid,
    input  logic               i_coef_ready,
    output logic [7:0]         o_coef_idx,
    output logic               o_done,
    output logic               o_busy
`ifdef REJ_SAMPLER_STATS_EN
    ,
    output logic [15:0]        o_rej_cnt
`endif
);

    localparam int BW_BUF = 2 * BW_DATA;
    localparam int BW_CNT = $clog2(BW_BUF + 1);
    localparam int BW_CC  = $clog2(NCOEF + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [BW_COEF-1:0] Q_L      = BW_COEF'(Q);
    localparam logic [BW_CC-1:0]   NCOEF_L  = BW_CC'(NCOEF);
    localparam logic [BW_CNT-1:0]  DATA_L   = BW_CNT'(BW_DATA);
    localparam logic [BW_CNT-1:0]  COEF_L   = BW_CNT'(BW_COEF);
    localparam logic [7:0]         LAST_IDX = 8'(NCOEF - 1);

    logic [1:0]         state;
    logic [BW_BUF-1:0]  sbuf;
    logic [BW_CNT-1:0]  bcnt;
    logic [BW_CC-1:0]   coef_cnt;

    logic               run;
    logic               acc;
    logic               ext;
    logic               accept;
    logic               last_hs;
    logic [BW_COEF-1:0] cand;
    logic [BW_BUF-1:0]  buf_shift;
    logic [BW_BUF-1:0]  buf_next;
    logic [BW_CNT-1:0]  pos;
    logic [BW_CNT-1:0]  bcnt_next;

    assign run            = (state == ST_RUN);
    assign o_ibytes_ready = run && (bcnt <= DATA_L);
    assign o_done         = (state == ST_DONE);
    assign o_busy         = (state != ST_IDLE);

    assign acc  = o_ibytes_ready && i_ibytes_valid;
    assign cand = sbuf[BW_COEF-1:0];
    // Extraction stops once NCOEF coefficients are loaded so no extra one slips out.
    assign ext    = run && (bcnt >= COEF_L) && (coef_cnt < NCOEF_L)
                    && (!o_coef_valid || i_coef_ready);
    assign accept = ext && (cand < Q_L);
    assign last_hs = o_coef_valid && i_coef_ready && (o_coef_idx == LAST_IDX);

    // Shift out the candidate first, then append the new word right above the remaining bits.
    always_comb begin
        buf_shift = ext ? (sbuf >> BW_COEF) : sbuf;
        pos       = ext ? (bcnt - COEF_L) : bcnt;
        buf_next  = buf_shift;
        bcnt_next = pos;
        if (acc) begin
            buf_next  = buf_shift | ({{BW_DATA{1'b0}}, i_ibytes} << pos);
            bcnt_next = pos + DATA_L;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            sbuf         <= '0;
            bcnt         <= '0;
            coef_cnt     <= '0;
            o_coef       <= '0;
            o_coef_valid <= 1'b0;
            o_coef_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state        <= ST_RUN;
                        sbuf         <= '0;
                        bcnt         <= '0;
                        coef_cnt     <= '0;
                        o_coef       <= '0;
                        o_coef_valid <= 1'b0;
                        o_coef_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    sbuf <= buf_next;
                    bcnt <= bcnt_next;
                    if (accept) begin
                        o_coef       <= cand;
                        o_coef_valid <= 1'b1;
                        o_coef_idx   <= coef_cnt[7:0];
                        coef_cnt     <= coef_cnt + 1'b1;
                    end else if (o_coef_valid && i_coef_ready) begin
                        o_coef_valid <= 1'b0;
                    end
                    if (last_hs) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    sbuf  <= '0;
                    bcnt  <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef REJ_SAMPLER_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rej_cnt <= '0;
        end else if ((state == ST_IDLE) && i_start) begin
            o_rej_cnt <= '0;
        end else if (ext && !accept && (o_rej_cnt != 16'hFFFF)) begin
            o_rej_cnt <= o_rej_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kyber_rej_sampler.sv
// tb/tb_kyber_rej_sampler.sv - table vectors plus random streams checked against a byte-level Parse model.
module tb_kyber_rej_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] ibytes;
    logic        ibytes_valid;
    logic        ibytes_ready;
    logic [11:0] coef;
    logic        coef_valid;
    logic        coef_ready;
    logic [7:0]  coef_idx;
    logic        done;
    logic        busy;
`ifdef REJ_SAMPLER_STATS_EN
    logic [15:0] rej_cnt;
`endif

    always #5 clk = ~clk;

    kyber_rej_sampler dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_ibytes       (ibytes),
        .i_ibytes_valid (ibytes_valid),
        .o_ibytes_ready (ibytes_ready),
        .o_coef         (coef),
        .o_coef_valid   (coef_valid),
        .i_coef_ready   (coef_ready),
        .o_coef_idx     (coef_idx),
        .o_done         (done),
        .o_busy         (busy)
`ifdef REJ_SAMPLER_STATS_EN
        ,
        .o_rej_cnt      (rej_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] src_words[200];
    int got_coef[$];
    int got_idx[$];
    int exp_q[$];
    int exp_rej;
    int done_cnt;
    int first_hs;
    int first_val;
    int words_used;

    typedef struct {
        logic [59:0] cands;
        int          n;
        logic [59:0] exp;
    } vec_t;
    vec_t vt[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Parse from the byte stream: every 3 bytes give two 12-bit candidates.
    function automatic void model(input int nwords);
        int nb;
        int b0, b1, b2, d1, d2;
        exp_q.delete();
        exp_rej = 0;
        nb = 8 * nwords;
        for (int j = 0; j + 2 < nb && exp_q.size() < 256; j += 3) begin
            b0 = int'(src_words[j / 8][8 * (j % 8) +: 8]);
            b1 = int'(src_words[(j + 1) / 8][8 * ((j + 1) % 8) +: 8]);
            b2 = int'(src_words[(j + 2) / 8][8 * ((j + 2) % 8) +: 8]);
            d1 = b0 + 256 * (b1 % 16);
            d2 = (b1 / 16) + 16 * b2;
            if (d1 < 3329) exp_q.push_back(d1);
            else exp_rej++;
            if (exp_q.size() < 256) begin
                if (d2 < 3329) exp_q.push_back(d2);
                else exp_rej++;
            end
        end
    endfunction

    task automatic do_reset(input bit chk);
        rst          = 1'b1;
        start        = 1'b0;
        ibytes_valid = 1'b1;
        ibytes       = '1;
        coef_ready   = 1'b0;
        repeat (3) @(negedge clk);
        if (chk) begin
            check("rst_coef", coef, 0);
            check("rst_coef_valid", coef_valid, 0);
            check("rst_coef_idx", coef_idx, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_ibytes_ready", ibytes_ready, 0);
`ifdef REJ_SAMPLER_STATS_EN
            check("rst_rej_cnt", rej_cnt, 0);
`endif
        end
        rst          = 1'b0;
        ibytes_valid = 1'b0;
        ibytes       = '0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 one cycle on / two off, 2 random.
    task automatic drive(input int nwords, input int rdy_mode, input int max_cyc, input int abort_idx);
        int wi = 0;
        int after_done = 0;
        bit prev_stall = 1'b0;
        bit stop = 1'b0;
        logic [11:0] hc = '0;
        logic [7:0]  hi = '0;
        got_coef.delete();
        got_idx.delete();
        done_cnt  = 0;
        first_hs  = -1;
        first_val = -1;
        for (int cyc = 0; cyc < max_cyc && !stop; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_coef", coef, hc);
                check("hold_idx", coef_idx, hi);
            end
            if (done) done_cnt++;
            if (coef_valid && first_val < 0) first_val = cyc;
            case (rdy_mode)
                0:       coef_ready = 1'b1;
                1:       coef_ready = (cyc % 3 == 0);
                default: coef_ready = 1'($urandom_range(0, 1));
            endcase
            ibytes_valid = (wi < nwords);
            ibytes       = (wi < nwords) ? src_words[wi] : 64'd0;
            if (ibytes_valid && ibytes_ready) begin
                if (first_hs < 0) first_hs = cyc;
                wi++;
            end
            if (coef_valid && coef_ready) begin
                got_coef.push_back(int'(coef));
                got_idx.push_back(int'(coef_idx));
                if (int'(coef_idx) == abort_idx) stop = 1'b1;
            end
            prev_stall = coef_valid && !coef_ready;
            hc = coef;
            hi = coef_idx;
            if (done_cnt > 0) after_done++;
            if (after_done >= 4) stop = 1'b1;
        end
        words_used = wi;
    endtask

    task automatic check_list(input string tag);
        check({tag, "_count"}, got_coef.size(), exp_q.size());
        for (int k = 0; k < got_coef.size() && k < exp_q.size(); k++) begin
            check({tag, "_coef"}, got_coef[k], exp_q[k]);
            check({tag, "_idx"}, got_idx[k], k);
        end
    endtask

    task automatic fill_random(input int nwords);
        for (int w = 0; w < nwords; w++) src_words[w] = {$urandom, $urandom};
    endtask

    initial begin
        vt[0] = '{{12'd0, 12'd0, 12'd0, 12'd3329, 12'd3328}, 4,
                  {12'd0, 12'd0, 12'd0, 12'd0, 12'd3328}};
        vt[1] = '{{12'd3329, 12'd3329, 12'd3329, 12'd3329, 12'd3329}, 0, 60'd0};
        vt[2] = '{{12'd5, 12'd4, 12'd3, 12'd2, 12'd1}, 5,
                  {12'd5, 12'd4, 12'd3, 12'd2, 12'd1}};
        vt[3] = '{{12'd4000, 12'd0, 12'd3330, 12'd3328, 12'd4095}, 2,
                  {12'd0, 12'd0, 12'd0, 12'd0, 12'd3328}};
        vt[4] = '{{12'd1234, 12'd4095, 12'd4095, 12'd4095, 12'd3327}, 2,
                  {12'd0, 12'd0, 12'd0, 12'd1234, 12'd3327}};

        do_reset(1'b1);

        // Single-word vectors, including the 3328/3329 boundary word.
        for (int v = 0; v < 5; v++) begin
            do_reset(1'b0);
            do_start();
            check("start_busy", busy, 1);
            src_words[0] = {(v == 0) ? 4'h0 : 4'hB, vt[v].cands};
            drive(1, 0, 15, -1);
            check("vec_count", got_coef.size(), vt[v].n);
            for (int k = 0; k < got_coef.size() && k < vt[v].n; k++) begin
                check("vec_coef", got_coef[k], vt[v].exp[12 * k +: 12]);
                check("vec_idx", got_idx[k], k);
            end
            if (vt[v].cands[11:0] < 12'd3329) check("first_latency", first_val - first_hs, 2);
`ifdef REJ_SAMPLER_STATS_EN
            check("vec_rej_cnt", rej_cnt, 5 - vt[v].n);
`endif
        end

        // All-reject stream: every word consumed, nothing emitted.
        do_reset(1'b0);
        do_start();
        for (int w = 0; w < 16; w++) src_words[w] = '1;
        drive(16, 0, 200, -1);
        check("allrej_count", got_coef.size(), 0);
        check("allrej_no_valid", first_val, -1);
        check("allrej_words", words_used, 16);
`ifdef REJ_SAMPLER_STATS_EN
        check("allrej_rej_cnt", rej_cnt, 85);
`endif

        // Backpressure with all-zero words.
        do_reset(1'b0);
        do_start();
        for (int w = 0; w < 60; w++) src_words[w] = '0;
        model(60);
        drive(60, 1, 3000, -1);
        check_list("bp");
        check("bp_done_pulses", done_cnt, 1);
        check("bp_ready_after", ibytes_ready, 0);
        check("bp_busy_after", busy, 0);

        // Full random polynomial with random backpressure.
        do_reset(1'b0);
        do_start();
        fill_random(100);
        model(100);
        drive(100, 2, 4000, -1);
        check_list("rnd");
        check("rnd_done_pulses", done_cnt, 1);
        check("rnd_ready_after", ibytes_ready, 0);
`ifdef REJ_SAMPLER_STATS_EN
        check("rnd_rej_cnt", rej_cnt, exp_rej);
`endif

        // Reset in the middle of a polynomial, then a fresh one.
        do_reset(1'b0);
        do_start();
        fill_random(100);
        model(100);
        drive(100, 0, 2000, 100);
        check("abort_count", got_coef.size(), 101);
        check("abort_no_done", done_cnt, 0);
        do_reset(1'b1);
        do_start();
        fill_random(100);
        model(100);
        drive(100, 0, 2000, -1);
        check_list("fresh");
        check("fresh_done_pulses", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
